window_close_scheduler: RTL and testbench
=========================================

# window_close_scheduler

Sequencer for the shared window-actuator driver. It takes per-room close requests from the weather alarm (`window_close_cmd`) and window position feedback (`windowState`). It drives at most one window motor at a time, since the shared supply cannot power two actuators at once. Requests are served round-robin, each drive is bounded by a timeout, and a dead-time gap separates consecutive drives. Failed windows are latched as faults.

## Interface
- `N_WIN`, 8: number of windows/rooms; index width is 3 for the default.
- `MOVE_TIMEOUT`, 16'd1000: maximum drive cycles per closure; legal range 1..65535.
- `SETTLE_CYCLES`, 8'd4: motor-off dead time after each drive; legal range 1..255.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `close_req`  in  N_WIN  per-window close request (level), driven from `window_close_cmd`.
- `window_open`  in  N_WIN  position feedback (`windowState`): 1 = open, 0 = closed.
- `fault_clr`  in  1  one-cycle pulse; clears all `fault` bits.
- `motor_en`  out  N_WIN  one-hot-or-zero close-motor enable.
- `busy`  out  1  high in DRIVE or SETTLE.
- `cur_idx`  out  3  index of the window being driven or most recently driven.
- `done`  out  1  one-cycle pulse when a closure is confirmed.
- `fault`  out  N_WIN  sticky per-window timeout flag.

## Operation
- Pending set: `pend = close_req & window_open & ~fault`.
- Round-robin pointer `last` resets to N_WIN-1, so after reset index 0 has top priority.
- Search order: `last+1`, `last+2`, … wrapping modulo N_WIN.
- States:
  - **IDLE**: `motor_en`=0. If `pend` != 0, select the first pending index in search order, load `cur_idx`, set `last` = that index, clear the timer, and go to DRIVE. Otherwise stay in IDLE.
  - **DRIVE**: `motor_en[cur_idx]`=1 and the timer increments each cycle.
    - Exit checks use this priority: (1) `window_open[cur_idx]`==0 gives success: pulse `done`, go to SETTLE. (2) `close_req[cur_idx]`==0 gives abort: no `done`, no fault, go to SETTLE. (3) timer == MOVE_TIMEOUT-1 gives timeout: set `fault[cur_idx]`, go to SETTLE.
  - **SETTLE**: `motor_en`=0 and the timer counts SETTLE_CYCLES cycles, then the block returns to IDLE. Requests arriving in SETTLE wait; they are not lost, because `close_req` is a level.
- Faulted windows are excluded from arbitration until `fault_clr`.
- `fault_clr` clears every bit. If a timeout set and a clear occur in the same cycle, the set wins for that bit.
- A window already closed (`window_open`=0) with `close_req`=1 is never driven.
- `motor_en` is registered and is never multi-hot. `motor_en` and SETTLE are mutually exclusive.
- Reset values: state IDLE, `motor_en`=0, `busy`=0, `cur_idx`=0, `done`=0, `fault`=0, timer=0, `last`=N_WIN-1.
- Reset mid-drive: `motor_en` drops at the reset edge. Faults and the pointer reinitialise.

## Timing
- Grant latency: with `pend` nonzero in IDLE at edge k, `motor_en` and `busy` go high after edge k.
- Maximum drive length is MOVE_TIMEOUT cycles with `motor_en` high.
- Closure latency: with `window_open[cur_idx]` sampled 0 at edge k, the block does the following after edge k:
  - `motor_en`=0
  - `done`=1 for exactly one cycle
  - state becomes SETTLE
- SETTLE lasts exactly SETTLE_CYCLES cycles with `busy`=1.
- Gap between consecutive drives is SETTLE_CYCLES + 1 cycles (the extra cycle is IDLE).
- `fault` bit set and `motor_en` drop occur on the same edge.
- Inputs are synchronous to `clk`; no internal synchronisers.

## Test plan
Benches use MOVE_TIMEOUT=8 and SETTLE_CYCLES=2.

1. **Reset:** hold `rst_n`=0 for 3 cycles with `close_req`=8'hFF and `window_open`=8'hFF. Required: all outputs 0 throughout. `motor_en`=8'h01 one cycle after release.
2. **Single closure:** `close_req`=8'h10, `window_open`=8'h10, window closes after 3 drive cycles. Required:
   - `motor_en`=8'h10 for 3 cycles
   - `done` pulse, `cur_idx`=4
   - `busy` high for 2 more cycles, then IDLE
3. **Round-robin:** `close_req`=`window_open`=8'h81 held; each window closes after 2 cycles. Required:
   - grant order 0 then 7, with 3 idle/settle cycles between drives
   - after 7 closes and bit 0 is re-opened, the next grant is 0
4. **Timeout:** `close_req`=8'h04, `window_open` stuck at 8'h04. Required:
   - `motor_en`=8'h04 for exactly 8 cycles, then `fault`=8'h04, no `done`
   - window 2 is never re-driven
   - after a `fault_clr` pulse, window 2 is driven again
5. **Abort and same-cycle set/clear:**
   - Drop `close_req[3]` on drive cycle 2: `motor_en` drops next edge, `fault` stays 0, no `done`.
   - Pulse `fault_clr` in the same cycle as a timeout on window 5: `fault[5]`=1.
6. **Reset mid-drive:** assert `rst_n`=0 on drive cycle 4 of window 6. Required: `motor_en`=0 at that edge, `fault`=0, next grant starts search at index 0.

Source files
------------

// File: rtl/window_close_scheduler.sv
// window_close_scheduler
// Sequencer for the shared window-actuator driver. Weather-alarm close requests
// are served round-robin, one motor at a time. Each drive is bounded by a
// timeout and followed by a motor-off dead time. Windows that time out are
// latched as faults and are skipped until a fault clear.
module window_close_scheduler #(
  parameter int          N_WIN         = 8,
  parameter logic [15:0] MOVE_TIMEOUT  = 16'd1000,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd4,
  localparam int         IDX_W         = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_WIN-1:0] close_req,
  input  logic [N_WIN-1:0] window_open,
  input  logic             fault_clr,
  output logic [N_WIN-1:0] motor_en,
  output logic             busy,
  output logic [IDX_W-1:0] cur_idx,
  output logic             done,
  output logic [N_WIN-1:0] fault
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE
  } state_t;

  state_t           state;
  state_t           state_nx;

  // One timer serves both the drive timeout and the settle dead time; it is
  // cleared on every state change so each phase starts counting from zero.
  logic [15:0]      timer;
  logic [15:0]      timer_nx;

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] last_nx;
  logic [IDX_W-1:0] cur_idx_nx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;

  logic [N_WIN-1:0] pend;
  logic [N_WIN-1:0] motor_en_nx;
  logic [N_WIN-1:0] fault_set;
  logic [N_WIN-1:0] fault_nx;
  logic             done_nx;

  logic             hit_closed;
  logic             hit_abort;
  logic             hit_timeout;
  logic             settle_end;

  // Windows eligible for a drive: requested, still open, not faulted.
  assign pend = close_req & window_open & ~fault;

  // Drive exit conditions for the window currently granted; priority is
  // resolved where they are used (closed, then abort, then timeout).
  assign hit_closed  = ~window_open[cur_idx];
  assign hit_abort   = ~close_req[cur_idx];
  assign hit_timeout = (timer == MOVE_TIMEOUT - 16'd1);
  assign settle_end  = (timer == {8'd0, SETTLE_CYCLES - 8'd1});

  assign busy = (state != ST_IDLE);

  // Round-robin pick: first pending window after the last one granted.
  always_comb begin : rr_search
    logic [IDX_W-1:0] cand;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it holding a value and no latch is inferred.
    sel_found = 1'b0;
    sel_idx   = last;
    cand      = last;
    for (int i = 0; i < N_WIN; i++) begin
      cand = (cand == IDX_W'(N_WIN - 1)) ? '0 : cand + IDX_W'(1);
      if (!sel_found && pend[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- it is only seen on a rising clock edge,
    // so it lives inside the clocked branch rather than the sensitivity list.
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers
      // update together from values sampled before the edge.
      state <= state_nx;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hit_closed || hit_abort || hit_timeout) begin
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_end) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, timer, grant index and pointer.
  always_comb begin
    motor_en_nx = '0;
    done_nx     = 1'b0;
    fault_set   = '0;
    timer_nx    = timer;
    cur_idx_nx  = cur_idx;
    last_nx     = last;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          motor_en_nx[sel_idx] = 1'b1;
          cur_idx_nx           = sel_idx;
          last_nx              = sel_idx;
          timer_nx             = '0;
        end
      end
      ST_DRIVE: begin
        if (hit_closed) begin
          done_nx  = 1'b1;
          timer_nx = '0;
        end else if (hit_abort) begin
          timer_nx = '0;
        end else if (hit_timeout) begin
          fault_set[cur_idx] = 1'b1;
          timer_nx           = '0;
        end else begin
          motor_en_nx = motor_en;
          timer_nx    = timer + 16'd1;
        end
      end
      ST_SETTLE: begin
        timer_nx = settle_end ? '0 : timer + 16'd1;
      end
      default: begin
        timer_nx = '0;
      end
    endcase
    // A timeout in the same cycle as a clear keeps its fault bit.
    fault_nx = (fault & ~{N_WIN{fault_clr}}) | fault_set;
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      motor_en <= '0;
      done     <= 1'b0;
      fault    <= '0;
      timer    <= '0;
      cur_idx  <= '0;
      last     <= IDX_W'(N_WIN - 1);
    end else begin
      motor_en <= motor_en_nx;
      done     <= done_nx;
      fault    <= fault_nx;
      timer    <= timer_nx;
      cur_idx  <= cur_idx_nx;
      last     <= last_nx;
    end
  end

endmodule

// File: tb/tb_window_close_scheduler.sv
// Bench for window_close_scheduler with MOVE_TIMEOUT=8, SETTLE_CYCLES=2.
// Directed scenarios followed by randomized traffic; a phase-level reference
// model predicts every output after every clock edge.
module tb_window_close_scheduler;

  localparam int N  = 8;
  localparam int MT = 8;
  localparam int SC = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] close_req;
  logic [7:0] window_open;
  logic       fault_clr;
  logic [7:0] motor_en;
  logic       busy;
  logic [2:0] cur_idx;
  logic       done;
  logic [7:0] fault;

  window_close_scheduler #(
    .N_WIN        (N),
    .MOVE_TIMEOUT (16'd8),
    .SETTLE_CYCLES(8'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .close_req  (close_req),
    .window_open(window_open),
    .fault_clr  (fault_clr),
    .motor_en   (motor_en),
    .busy       (busy),
    .cur_idx    (cur_idx),
    .done       (done),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_DRIVE, M_SETTLE} mphase_t;
  mphase_t    m_phase = M_IDLE;
  logic [7:0] m_motor = '0;
  logic [7:0] m_fault = '0;
  logic       m_done  = 1'b0;
  int         m_cur   = 0;
  int         m_last  = N - 1;
  int         m_drive_n;     // 1-based number of the current drive cycle
  int         m_settle_left; // settle cycles still to run, including this one

  function automatic int rr_pick(input logic [7:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [7:0] req, input logic [7:0] open,
                              input logic clr, input logic rn);
    logic [7:0] set_bit;
    logic [7:0] pend;
    bit         finish;
    set_bit = '0;
    finish  = 1'b0;
    if (!rn) begin
      m_phase = M_IDLE;
      m_motor = '0;
      m_fault = '0;
      m_done  = 1'b0;
      m_cur   = 0;
      m_last  = N - 1;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        M_IDLE: begin
          pend = req & open & ~m_fault;
          if (pend != 0) begin
            m_cur     = rr_pick(pend, m_last);
            m_last    = m_cur;
            m_drive_n = 1;
            m_phase   = M_DRIVE;
            m_motor   = 8'd1 << m_cur;
          end
        end
        M_DRIVE: begin
          if (!open[m_cur]) begin
            m_done = 1'b1;
            finish = 1'b1;
          end else if (!req[m_cur]) begin
            finish = 1'b1;
          end else if (m_drive_n == MT) begin
            set_bit[m_cur] = 1'b1;
            finish = 1'b1;
          end else begin
            m_drive_n++;
          end
          if (finish) begin
            m_phase       = M_SETTLE;
            m_settle_left = SC;
            m_motor       = '0;
          end
        end
        default: begin
          m_settle_left--;
          if (m_settle_left == 0) m_phase = M_IDLE;
        end
      endcase
      m_fault = (clr ? 8'd0 : m_fault) | set_bit;
    end
  endtask

  // One clock: capture the inputs the edge will sample, advance model, compare.
  task automatic tick();
    logic [7:0] r;
    logic [7:0] o;
    logic       c;
    logic       rn;
    r  = close_req;
    o  = window_open;
    c  = fault_clr;
    rn = rst_n;
    @(posedge clk);
    #1;
    model_update(r, o, c, rn);
    check("model_motor_en", motor_en, m_motor);
    check("model_busy", busy, (m_phase != M_IDLE));
    check("model_done", done, m_done);
    check("model_fault", fault, m_fault);
    check("model_cur_idx", cur_idx, m_cur);
  endtask

  task automatic drain();
    close_req = '0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_on;
    logic       saw_done;
    logic [7:0] any_motor;
    logic [7:0] stuck;

    rst_n       = 1'b0;
    close_req   = 8'hFF;
    window_open = 8'hFF;
    fault_clr   = 1'b0;

    // 1. Reset held with everything requested: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_motor_en", motor_en, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_fault", fault, 8'h00);
      check("rst_cur_idx", cur_idx, 3'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rst_first_grant", motor_en, 8'h01);
    check("rst_first_busy", busy, 1'b1);
    window_open = '0;
    drain();

    // 2. Single closure of window 4 after three drive cycles.
    close_req   = 8'h10;
    window_open = 8'h10;
    tick();
    check("single_grant", motor_en, 8'h10);
    check("single_idx", cur_idx, 3'd4);
    tick();
    check("single_drive2", motor_en, 8'h10);
    tick();
    check("single_drive3", motor_en, 8'h10);
    window_open = 8'h00;
    tick();
    check("single_motor_off", motor_en, 8'h00);
    check("single_done", done, 1'b1);
    check("single_done_idx", cur_idx, 3'd4);
    check("single_settle1", busy, 1'b1);
    tick();
    check("single_done_once", done, 1'b0);
    check("single_settle2", busy, 1'b1);
    tick();
    check("single_idle", busy, 1'b0);
    close_req = '0;

    // 3. Round-robin between windows 0 and 7 from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    close_req   = 8'h81;
    window_open = 8'h81;
    tick();
    check("rr_first_0", motor_en, 8'h01);
    tick();
    window_open = 8'h80;
    tick();
    check("rr_done_0", done, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("rr_gap_off", motor_en, 8'h00);
      tick();
    end
    check("rr_second_7", motor_en, 8'h80);
    check("rr_second_idx", cur_idx, 3'd7);
    tick();
    window_open = 8'h01;
    tick();
    check("rr_done_7", done, 1'b1);
    tick();
    tick();
    tick();
    check("rr_back_to_0", motor_en, 8'h01);
    drain();
    window_open = '0;

    // 4. Timeout on a stuck window 2, exclusion, then fault clear.
    close_req   = 8'h04;
    window_open = 8'h04;
    tick();
    n_on     = (motor_en == 8'h04) ? 1 : 0;
    saw_done = done;
    for (int i = 0; i < 20; i++) begin
      tick();
      saw_done |= done;
      if (motor_en == 8'h04) n_on++;
      else break;
    end
    check("to_drive_len", n_on, MT);
    check("to_fault", fault, 8'h04);
    check("to_no_done", saw_done, 1'b0);
    any_motor = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_motor |= motor_en;
    end
    check("to_not_redriven", any_motor, 8'h00);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("to_fault_cleared", fault, 8'h00);
    tick();
    check("to_redrive", motor_en, 8'h04);
    drain();
    window_open = '0;

    // 5a. Abort: request for window 3 dropped on drive cycle 2.
    close_req   = 8'h08;
    window_open = 8'h08;
    tick();
    check("abort_grant", motor_en, 8'h08);
    tick();
    check("abort_drive2", motor_en, 8'h08);
    close_req = 8'h00;
    tick();
    check("abort_motor_off", motor_en, 8'h00);
    check("abort_no_fault", fault, 8'h00);
    check("abort_no_done", done, 1'b0);
    check("abort_settle", busy, 1'b1);
    drain();
    window_open = '0;

    // 5b. Timeout on window 5 coinciding with fault_clr: set wins.
    close_req   = 8'h20;
    window_open = 8'h20;
    tick();
    check("setclr_grant", motor_en, 8'h20);
    for (int i = 0; i < MT - 1; i++) tick();
    check("setclr_last_drive", motor_en, 8'h20);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("setclr_fault_wins", fault, 8'h20);
    check("setclr_motor_off", motor_en, 8'h00);
    drain();
    window_open = '0;

    // 6. Reset on drive cycle 4 of window 6 (fault[5] still set).
    close_req   = 8'h40;
    window_open = 8'h40;
    tick();
    check("rmid_grant", motor_en, 8'h40);
    tick();
    tick();
    tick();
    check("rmid_drive4", motor_en, 8'h40);
    rst_n       = 1'b0;
    close_req   = 8'hFF;
    window_open = 8'hFF;
    tick();
    check("rmid_motor_off", motor_en, 8'h00);
    check("rmid_fault_clr", fault, 8'h00);
    check("rmid_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rmid_grant_0", motor_en, 8'h01);
    window_open = '0;
    drain();

    // Randomized traffic against the model.
    stuck = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) close_req = 8'($urandom);
      if ($urandom_range(0, 15) == 0) window_open = window_open | (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) stuck = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 2) == 0) window_open = window_open & ~(motor_en & ~stuck);
      fault_clr = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n     = 1'b1;
    fault_clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
